// File: rtl/rpc2_ctrl_axi3_wr_addr_control_if.sv
// AW/W/B, packing-stage and memory-command signals of the RPC2 write-address controller.
// Handshakes use valid/ready: a transfer happens on the clk edge where both are high.
interface rpc2_ctrl_axi3_wr_addr_control_if #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int NB = DATA_W / 8;

  logic [ID_W-1:0]   axi_awid;
  logic [ADDR_W-1:0] axi_awaddr;
  logic [3:0]        axi_awlen;
  logic [2:0]        axi_awsize;
  logic [1:0]        axi_awburst;
  logic              axi_awvalid;
  logic              axi_awready;
  logic              axi_wready;
  logic [ID_W-1:0]   axi_bid;
  logic [1:0]        axi_bresp;
  logic              axi_bvalid;
  logic              axi_bready;
  logic              wready_req;
  logic [1:0]        wready_size;
  logic              wready_fixed;
  logic [NB-1:0]     wready_strb;
  logic [ID_W-1:0]   wready_id;
  logic              wready_done;
  logic              wdat_full;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [3:0]        cmd_len;
  logic [2:0]        cmd_size;
  logic [1:0]        cmd_burst;
  logic [2:0]        state_dbg;

  modport slave (
    input  axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awvalid,
    input  axi_bready, wready_done, wdat_full, cmd_ready,
    output axi_awready, axi_wready, axi_bid, axi_bresp, axi_bvalid,
    output wready_req, wready_size, wready_fixed, wready_strb, wready_id,
    output cmd_valid, cmd_addr, cmd_len, cmd_size, cmd_burst, state_dbg
  );

  modport master (
    output axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awvalid,
    output axi_bready, wready_done, wdat_full, cmd_ready,
    input  axi_awready, axi_wready, axi_bid, axi_bresp, axi_bvalid,
    input  wready_req, wready_size, wready_fixed, wready_strb, wready_id,
    input  cmd_valid, cmd_addr, cmd_len, cmd_size, cmd_burst, state_dbg
  );
endinterface

// File: rtl/rpc2_ctrl_axi3_wr_addr_control.sv
// Single-outstanding AXI3 write-address/response controller: captures one AW burst,
// issues the memory command, gates WREADY during packing and returns the B response.
module rpc2_ctrl_axi3_wr_addr_control #(
  parameter int C_AXI_ID_WIDTH   = 4,
  parameter int C_AXI_ADDR_WIDTH = 32,
  parameter int C_AXI_DATA_WIDTH = 32
) (
  input logic clk,
  input logic reset,
  rpc2_ctrl_axi3_wr_addr_control_if.slave bus
);
  localparam int NB = C_AXI_DATA_WIDTH / 8;
  localparam int AB = $clog2(NB);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_CMD  = 3'd2,
    S_DATA = 3'd3,
    S_RESP = 3'd4
  } state_t;

  state_t state, state_next;
  logic   aw_ready_q;
  logic   aw_hs;

  logic [C_AXI_ID_WIDTH-1:0]   id_q;
  logic [C_AXI_ADDR_WIDTH-1:0] addr_q;
  logic [3:0]                  len_q;
  logic [2:0]                  size_q;
  logic [1:0]                  burst_q;
  logic                        fixed_q;
  logic                        err_q;
  logic [NB-1:0]               strb_q;

  logic [NB-1:0] strb_next;
  logic [4:0]    nbytes;
  logic [15:0]   lane_mask;
  logic [2:0]    lane_off;
  logic          err_next;

  assign aw_hs = (state == S_IDLE) && aw_ready_q && bus.axi_awvalid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      aw_ready_q <= 1'b0;
    end else begin
      state      <= state_next;
      aw_ready_q <= (state_next == S_IDLE);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (aw_hs) state_next = S_REQ;
      S_REQ:   state_next = S_CMD;
      S_CMD:   if (bus.cmd_ready) state_next = S_DATA;
      S_DATA:  if (bus.wready_done) state_next = S_RESP;
      S_RESP:  if (bus.axi_bready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.axi_awready = aw_ready_q;
    bus.wready_req  = (state == S_REQ);
    bus.cmd_valid   = (state == S_CMD);
    bus.axi_wready  = (state == S_DATA) && !bus.wdat_full;
    bus.axi_bvalid  = (state == S_RESP);
    bus.state_dbg   = state;
  end

  // First-beat lanes: a size-wide mask placed at the size-aligned offset within the bus word.
  always_comb begin
    nbytes    = 5'd1 << bus.axi_awsize[1:0];
    lane_mask = 16'((17'd1 << nbytes) - 17'd1);
    lane_off  = 3'(bus.axi_awaddr[AB-1:0]) & ~(nbytes[2:0] - 3'd1);
    strb_next = NB'(lane_mask << lane_off);
    err_next  = (bus.axi_awsize > 3'(AB)) || (bus.axi_awburst == 2'b11);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      fixed_q <= 1'b0;
      err_q   <= 1'b0;
      strb_q  <= '0;
    end else if (aw_hs) begin
      id_q    <= bus.axi_awid;
      addr_q  <= bus.axi_awaddr;
      len_q   <= bus.axi_awlen;
      size_q  <= bus.axi_awsize;
      burst_q <= bus.axi_awburst;
      fixed_q <= (bus.axi_awburst == 2'b00);
      err_q   <= err_next;
      strb_q  <= strb_next;
    end
  end

  // Erroneous bursts still run the full flow; only the response code reports them.
  assign bus.axi_bid      = id_q;
  assign bus.axi_bresp    = err_q ? 2'b10 : 2'b00;
  assign bus.wready_size  = size_q[1:0];
  assign bus.wready_fixed = fixed_q;
  assign bus.wready_strb  = strb_q;
  assign bus.wready_id    = id_q;
  assign bus.cmd_addr     = addr_q;
  assign bus.cmd_len      = len_q;
  assign bus.cmd_size     = size_q;
  assign bus.cmd_burst    = burst_q;
endmodule

// File: tb/tb_rpc2_ctrl_axi3_wr_addr_control.sv
// Directed bench for the write-address controller: vector table for full bursts plus
// hand-written stall, backpressure, wide-bus and mid-burst reset sequences.
module tb_rpc2_ctrl_axi3_wr_addr_control;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  rpc2_ctrl_axi3_wr_addr_control_if #(.ID_W(4), .ADDR_W(32), .DATA_W(32)) bus32 ();
  rpc2_ctrl_axi3_wr_addr_control_if #(.ID_W(4), .ADDR_W(32), .DATA_W(64)) bus64 ();

  rpc2_ctrl_axi3_wr_addr_control #(
    .C_AXI_ID_WIDTH(4), .C_AXI_ADDR_WIDTH(32), .C_AXI_DATA_WIDTH(32)
  ) dut32 (.clk(clk), .reset(reset), .bus(bus32));

  rpc2_ctrl_axi3_wr_addr_control #(
    .C_AXI_ID_WIDTH(4), .C_AXI_ADDR_WIDTH(32), .C_AXI_DATA_WIDTH(64)
  ) dut64 (.clk(clk), .reset(reset), .bus(bus64));

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  len;
    logic [1:0]  burst;
    logic [3:0]  id;
    logic [3:0]  exp_strb;
    logic [1:0]  exp_size;
    logic        exp_fixed;
    logic [1:0]  exp_bresp;
  } vec_t;

  vec_t vecs[7];
  logic [5:0] exp_q[$];   // {bid, bresp} expected per accepted burst
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic aw_send(input logic [31:0] addr, input logic [2:0] size, input logic [3:0] len,
                         input logic [1:0] burst, input logic [3:0] id);
    int n;
    bus32.axi_awaddr  = addr;
    bus32.axi_awsize  = size;
    bus32.axi_awlen   = len;
    bus32.axi_awburst = burst;
    bus32.axi_awid    = id;
    bus32.axi_awvalid = 1'b1;
    n = 0;
    while (!bus32.axi_awready && n < 20) begin
      tick();
      n++;
    end
    check("aw_ready_timeout", 64'(n == 20), 64'd0);
    tick();
    bus32.axi_awvalid = 1'b0;
  endtask

  // Called in the first DATA cycle; drives len+1 beats then completes the B handshake.
  task automatic finish_burst(input logic [3:0] len);
    logic [5:0] exp;
    for (int b = 0; b < int'(len); b++) tick();
    bus32.wready_done = 1'b1;
    tick();
    bus32.wready_done = 1'b0;
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 6'h3f;
    check("resp_wready_low", 64'(bus32.axi_wready), 64'd0);
    check("resp_bvalid", 64'(bus32.axi_bvalid), 64'd1);
    check("resp_bid", 64'(bus32.axi_bid), 64'(exp[5:2]));
    check("resp_bresp", 64'(bus32.axi_bresp), 64'(exp[1:0]));
    bus32.axi_bready = 1'b1;
    tick();
    check("after_b_bvalid", 64'(bus32.axi_bvalid), 64'd0);
    check("after_b_awready", 64'(bus32.axi_awready), 64'd1);
  endtask

  task automatic run_vec(input vec_t v);
    aw_send(v.addr, v.size, v.len, v.burst, v.id);
    exp_q.push_back({v.id, v.exp_bresp});
    check("req_pulse", 64'(bus32.wready_req), 64'd1);
    check("req_awready", 64'(bus32.axi_awready), 64'd0);
    check("req_cmd_valid", 64'(bus32.cmd_valid), 64'd0);
    check("wready_strb", 64'(bus32.wready_strb), 64'(v.exp_strb));
    check("wready_size", 64'(bus32.wready_size), 64'(v.exp_size));
    check("wready_fixed", 64'(bus32.wready_fixed), 64'(v.exp_fixed));
    check("wready_id", 64'(bus32.wready_id), 64'(v.id));
    check("cmd_addr", 64'(bus32.cmd_addr), 64'(v.addr));
    check("cmd_len", 64'(bus32.cmd_len), 64'(v.len));
    check("cmd_size", 64'(bus32.cmd_size), 64'(v.size));
    check("cmd_burst", 64'(bus32.cmd_burst), 64'(v.burst));
    tick();
    check("req_one_cycle", 64'(bus32.wready_req), 64'd0);
    check("cmd_valid", 64'(bus32.cmd_valid), 64'd1);
    check("cmd_wready_low", 64'(bus32.axi_wready), 64'd0);
    tick();
    check("data_wready", 64'(bus32.axi_wready), 64'd1);
    check("data_cmd_valid_low", 64'(bus32.cmd_valid), 64'd0);
    finish_burst(v.len);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired (t=%0t)", $time);
    $fatal(1);
  end

  initial begin
    int n;
    vecs[0] = '{32'h1002, 3'd0, 4'd3, 2'b01, 4'h5, 4'b0100, 2'd0, 1'b0, 2'b00};
    vecs[1] = '{32'h2006, 3'd1, 4'd0, 2'b00, 4'hA, 4'b1100, 2'd1, 1'b1, 2'b00};
    vecs[2] = '{32'h3000, 3'd3, 4'd1, 2'b01, 4'h3, 4'b1111, 2'd3, 1'b0, 2'b10};
    vecs[3] = '{32'h4001, 3'd2, 4'd1, 2'b01, 4'h7, 4'b1111, 2'd2, 1'b0, 2'b00};
    vecs[4] = '{32'h5003, 3'd0, 4'd0, 2'b10, 4'hF, 4'b1000, 2'd0, 1'b0, 2'b00};
    vecs[5] = '{32'h6000, 3'd0, 4'd0, 2'b11, 4'h1, 4'b0001, 2'd0, 1'b0, 2'b10};
    vecs[6] = '{32'h7003, 3'd1, 4'd2, 2'b00, 4'h9, 4'b1100, 2'd1, 1'b1, 2'b00};

    bus32.axi_awid = '0; bus32.axi_awaddr = '0; bus32.axi_awlen = '0; bus32.axi_awsize = '0;
    bus32.axi_awburst = '0; bus32.axi_awvalid = 1'b0; bus32.axi_bready = 1'b1;
    bus32.wready_done = 1'b0; bus32.wdat_full = 1'b0; bus32.cmd_ready = 1'b1;
    bus64.axi_awid = '0; bus64.axi_awaddr = '0; bus64.axi_awlen = '0; bus64.axi_awsize = '0;
    bus64.axi_awburst = '0; bus64.axi_awvalid = 1'b0; bus64.axi_bready = 1'b1;
    bus64.wready_done = 1'b0; bus64.wdat_full = 1'b0; bus64.cmd_ready = 1'b1;

    // Reset values
    #2;
    check("rst_awready", 64'(bus32.axi_awready), 64'd0);
    check("rst_wready", 64'(bus32.axi_wready), 64'd0);
    check("rst_bvalid", 64'(bus32.axi_bvalid), 64'd0);
    check("rst_cmd_valid", 64'(bus32.cmd_valid), 64'd0);
    check("rst_strb", 64'(bus32.wready_strb), 64'd0);
    check("rst_fixed", 64'(bus32.wready_fixed), 64'd0);
    check("rst_state", 64'(bus32.state_dbg), 64'd0);
    tick();
    reset = 1'b0;
    #1;
    check("rst_release_awready_low", 64'(bus32.axi_awready), 64'd0);
    tick();
    check("first_edge_awready", 64'(bus32.axi_awready), 64'd1);

    // Back-to-back table bursts also exercise the 5-cycle AW spacing
    foreach (vecs[i]) run_vec(vecs[i]);

    // cmd_ready stall then wdat_full toggling in DATA
    bus32.cmd_ready = 1'b0;
    aw_send(32'h8004, 3'd2, 4'd1, 2'b01, 4'h6);
    exp_q.push_back({4'h6, 2'b00});
    tick();
    for (int c = 0; c < 10; c++) begin
      check("stall_cmd_valid", 64'(bus32.cmd_valid), 64'd1);
      check("stall_wready", 64'(bus32.axi_wready), 64'd0);
      check("stall_cmd_addr", 64'(bus32.cmd_addr), 64'h8004);
      tick();
    end
    bus32.cmd_ready = 1'b1;
    tick();
    check("stall_release_wready", 64'(bus32.axi_wready), 64'd1);
    bus32.wdat_full = 1'b1;
    #1;
    check("full_wready_low", 64'(bus32.axi_wready), 64'd0);
    bus32.wdat_full = 1'b0;
    #1;
    check("full_clear_wready", 64'(bus32.axi_wready), 64'd1);
    bus32.wdat_full = 1'b1;
    #1;
    check("full_again_wready_low", 64'(bus32.axi_wready), 64'd0);
    bus32.wdat_full = 1'b0;
    finish_burst(4'd1);

    // B backpressure with AWVALID held: no new AW may be taken
    bus32.axi_bready = 1'b0;
    aw_send(32'h9001, 3'd0, 4'd0, 2'b01, 4'h2);
    tick();
    tick();
    bus32.wready_done = 1'b1;
    tick();
    bus32.wready_done = 1'b0;
    bus32.axi_awaddr = 32'h9003;
    bus32.axi_awid = 4'hC;
    bus32.axi_awvalid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check("bp_awready", 64'(bus32.axi_awready), 64'd0);
      check("bp_bvalid", 64'(bus32.axi_bvalid), 64'd1);
      check("bp_no_req", 64'(bus32.wready_req), 64'd0);
      tick();
    end
    check("bp_strb_held", 64'(bus32.wready_strb), 64'b0010);
    check("bp_bid_held", 64'(bus32.axi_bid), 64'h2);
    bus32.axi_bready = 1'b1;
    tick();
    check("bp_after_awready", 64'(bus32.axi_awready), 64'd1);
    check("bp_after_bvalid", 64'(bus32.axi_bvalid), 64'd0);
    bus32.axi_awvalid = 1'b0;
    tick();

    // 64-bit bus: full-width first beat and in-range size
    bus64.axi_awaddr = 32'h0; bus64.axi_awsize = 3'd3; bus64.axi_awburst = 2'b01;
    bus64.axi_awid = 4'h4; bus64.axi_awvalid = 1'b1;
    n = 0;
    while (!bus64.axi_awready && n < 20) begin tick(); n++; end
    check("w64_aw_timeout", 64'(n == 20), 64'd0);
    tick();
    bus64.axi_awvalid = 1'b0;
    check("w64_strb", 64'(bus64.wready_strb), 64'hFF);
    check("w64_size", 64'(bus64.wready_size), 64'd3);
    tick();
    tick();
    bus64.wready_done = 1'b1;
    tick();
    bus64.wready_done = 1'b0;
    check("w64_bvalid", 64'(bus64.axi_bvalid), 64'd1);
    check("w64_bresp", 64'(bus64.axi_bresp), 64'd0);
    tick();

    // Reset during DATA drops the burst
    aw_send(32'hA002, 3'd1, 4'd3, 2'b01, 4'hB);
    tick();
    tick();
    check("pre_rst_wready", 64'(bus32.axi_wready), 64'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_wready", 64'(bus32.axi_wready), 64'd0);
    check("mid_rst_awready", 64'(bus32.axi_awready), 64'd0);
    check("mid_rst_bvalid", 64'(bus32.axi_bvalid), 64'd0);
    check("mid_rst_strb", 64'(bus32.wready_strb), 64'd0);
    check("mid_rst_id", 64'(bus32.wready_id), 64'd0);
    check("mid_rst_cmd_addr", 64'(bus32.cmd_addr), 64'd0);
    check("mid_rst_bid", 64'(bus32.axi_bid), 64'd0);
    check("mid_rst_state", 64'(bus32.state_dbg), 64'd0);
    tick();
    reset = 1'b0;
    bus32.wready_done = 1'b1;
    #1;
    check("post_rst_awready_low", 64'(bus32.axi_awready), 64'd0);
    tick();
    check("post_rst_awready", 64'(bus32.axi_awready), 64'd1);
    bus32.wready_done = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("post_rst_no_b", 64'(bus32.axi_bvalid), 64'd0);
      tick();
    end

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
